// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared state encoding and timing constants for the FIR control sequencer.
package fir_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LD_SETUP,
    LD_WR,
    LD_HOLD,
    RD,
    RD_DRAIN
  } state_t;
  localparam int NUM_TAP_DEF  = 10;
  localparam int RD_DRAIN_CYC = 2;
  localparam int LD_HOLD_CYC  = 3;
endpackage

// File: rtl/fir_ctrl_en_pipe.sv
// fir_ctrl_en_pipe: two-stage delay of the read-active signal into multiplier and accumulator enables.
module fir_ctrl_en_pipe (
  input  logic clk,
  input  logic rst,
  input  logic rd_active,
  output logic en_mul,
  output logic en_add_acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_mul     <= 1'b0;
      en_add_acc <= 1'b0;
    end else begin
      en_mul     <= rd_active;
      en_add_acc <= en_mul;
    end
  end
endmodule

// File: rtl/fir_ctrl_seq.sv
// fir_ctrl_seq: drives coefficient-load writes and per-sample read sweeps of ReConf_FirFilter.
// Define FIR_CTRL_SEQ_OVERRUN_EN to enable sticky detection of dropped strobes/requests.
module fir_ctrl_seq
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAP = NUM_TAP_DEF,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iEnSample600k,
  input  logic              iLoadReq,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oEnMul,
  output logic              oEnAddAcc,
  output logic              oBusy,
  output logic              oLoadDone,
  output logic              oSampleDone,
  output logic              oOverrun
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] TAP_N    = CW'(NUM_TAP);
  localparam logic [CW-1:0] TAP_LAST = CW'(NUM_TAP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(LD_HOLD_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_DRAIN_CYC - 1);
  state_t state, state_nx;
  logic [CW-1:0]     cnt;
  logic              hs;
  logic              rd_active;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  assign hs = iCoeffValid & oCoeffReady;
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = iEnSample600k ? RD : iLoadReq ? LD_SETUP : IDLE;
      LD_SETUP: state_nx = LD_WR;
      LD_WR:    state_nx = (hs && cnt == TAP_LAST) ? LD_HOLD : LD_WR;
      LD_HOLD:  state_nx = (cnt == HOLD_LAST) ? IDLE : LD_HOLD;
      RD:       state_nx = (cnt == TAP_LAST) ? RD_DRAIN : RD;
      RD_DRAIN: state_nx = (cnt == DRAIN_LAST) ? IDLE : RD_DRAIN;
      default:  state_nx = IDLE;
    endcase
  end
  // One counter serves every state: write index, read address, or hold/drain length.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      cnt         <= '0;
      wr_q        <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      oLoadDone   <= 1'b0;
      oSampleDone <= 1'b0;
    end else begin
      cnt         <= (state_nx != state || state == IDLE) ? '0 :
                     (state == LD_WR && !hs) ? cnt : cnt + CW'(1);
      wr_q        <= hs;
      wr_addr     <= cnt[ADDR_W-1:0];
      wr_data     <= iCoeffData;
      oLoadDone   <= state == LD_HOLD && state_nx == IDLE;
      oSampleDone <= state == RD_DRAIN && state_nx == IDLE;
    end
  end
  always_comb begin
    rd_active        = state == RD;
    oBusy            = state != IDLE;
    oCoeffUpdateFlag = state inside {LD_SETUP, LD_WR, LD_HOLD};
    oCoeffReady      = state == LD_WR && cnt < TAP_N;
    oCsnRam          = ~(rd_active | wr_q);
    oWrnRam          = ~wr_q;
    oAddrRam         = rd_active ? cnt[ADDR_W-1:0] : wr_q ? wr_addr : '0;
    oWtDtRam         = wr_q ? wr_data : '0;
  end
  fir_ctrl_en_pipe u_en_pipe (
    .clk        (iClk12M),
    .rst        (iRst),
    .rd_active  (rd_active),
    .en_mul     (oEnMul),
    .en_add_acc (oEnAddAcc)
  );
`ifdef FIR_CTRL_SEQ_OVERRUN_EN
  logic drop;
  assign drop = (state == IDLE) ? (iEnSample600k & iLoadReq) : (iEnSample600k | iLoadReq);
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) oOverrun <= 1'b0;
    else oOverrun <= oOverrun | drop;
  end
`else
  assign oOverrun = 1'b0;
`endif
endmodule
